// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding, default sizes, requester ids.
// No logic, so there is no latency.
// No backpressure; this file holds types and constants only.
package inst_mem_pkg;

  localparam int AW_DEF    = 10;  // 1024-word instruction memory
  localparam int DW_DEF    = 32;  // instruction word width
  localparam int BURST_DEF = 4;   // words per fetch burst

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_LDWR  = 3'd3,
    S_LDRD  = 3'd4
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LD    = 1'b1;

endpackage

// File: rtl/inst_rr_arb2.sv
// Two-way arbiter between the fetch unit and the host loader; optional macro INST_ARB_RR_EN.
// Grants are combinational from the qualified requests; the pointer updates on the granting edge.
// No backpressure: a losing requester simply keeps its request up until it is granted.
module inst_rr_arb2
  import inst_mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_f,
  input  logic i_req_l,
  output logic o_gnt_f,
  output logic o_gnt_l
);

`ifdef INST_ARB_RR_EN
  logic r_last;    // requester served most recently
  logic w_l_wins;

  // On a tie the requester that was not served last takes the port
  always_comb begin
    w_l_wins = 1'b0;
    if (i_req_l && !i_req_f) begin
      w_l_wins = 1'b1;
    end else if (i_req_l && i_req_f) begin
      w_l_wins = (r_last == REQ_FETCH);
    end
    o_gnt_l = w_l_wins;
    o_gnt_f = i_req_f && !w_l_wins;
  end

  // Pointer follows every grant; the reset value lets fetch win the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= REQ_LD;
    end else if (o_gnt_f) begin
      r_last <= REQ_FETCH;
    end else if (o_gnt_l) begin
      r_last <= REQ_LD;
    end
  end
`else
  // Clock and reset only feed the round-robin pointer, absent in this build
  logic w_unused;
  assign w_unused = i_clk ^ i_rst_n;

  // Fixed priority: the loader always wins, fetch takes the port only when the loader is quiet
  always_comb begin
    o_gnt_l = i_req_l;
    o_gnt_f = i_req_f && !i_req_l;
  end
`endif

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one single-port sync-read instruction memory between the host loader and the fetch unit; tie policy set by INST_ARB_RR_EN.
// Latency: f_req->f_gnt 1 cycle, f_gnt->first f_valid 2 cycles; loader ld_ack one cycle after its memory access.
// No fetch backpressure; requests are held by the requester until f_gnt/ld_ack, and a burst is never interrupted.
module inst_mem_arbiter
  import inst_mem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic          BRAM_clk,
  input  logic          BRAM_rst,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_data,
  output logic          f_last,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(BURST);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_base;
  logic [CW-1:0] r_cnt;
  logic          r_f_gnt;
  logic          r_ld_ack;
  logic          r_rd_ack;
  logic          r_rd_pend;
  logic          r_rd_last;
  logic          r_f_valid;
  logic          r_f_last;
  logic [DW-1:0] r_f_data;
  logic          w_idle;
  logic          w_ld_req;
  logic          w_gnt_f;
  logic          w_gnt_l;
  logic          w_cnt_end;

  assign w_idle    = (r_state == S_IDLE);
  // The loader is ignored in its own ack cycle so a request still up there is not served twice
  assign w_ld_req  = ld_req && !r_ld_ack;
  assign w_cnt_end = (r_cnt == CW'(BURST - 1));

  inst_rr_arb2 u_arb (
    .i_clk   (BRAM_clk),
    .i_rst_n (BRAM_rst),
    .i_req_f (w_idle && f_req),
    .i_req_l (w_idle && w_ld_req),
    .o_gnt_f (w_gnt_f),
    .o_gnt_l (w_gnt_l)
  );

  // State register
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the memory port; the port is idle (all zero) outside access states
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_f) begin
          w_next = S_FETCH;
        end else if (w_gnt_l) begin
          w_next = ld_we ? S_LDWR : S_LDRD;
        end
      end
      S_FETCH: begin
        mem_en   = 1'b1;
        mem_addr = r_base + AW'(r_cnt);   // wraps modulo 2^AW
        if (w_cnt_end) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      S_LDWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        w_next    = S_IDLE;
      end
      S_LDRD: begin
        mem_en   = 1'b1;
        mem_addr = ld_addr;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Burst base/counter plus the grant and ack pulses
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst) begin
      r_base   <= '0;
      r_cnt    <= '0;
      r_f_gnt  <= 1'b0;
      r_ld_ack <= 1'b0;
      r_rd_ack <= 1'b0;
    end else begin
      r_f_gnt <= w_gnt_f;
      if (w_gnt_f) begin
        r_base <= f_addr;
        r_cnt  <= '0;
      end else if (r_state == S_FETCH) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_ld_ack <= (r_state == S_LDWR) || (r_state == S_LDRD);
      r_rd_ack <= (r_state == S_LDRD);
    end
  end

  // Fetch return path: one stage to meet the synchronous read data, then the output register
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst) begin
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_f_valid <= 1'b0;
      r_f_last  <= 1'b0;
      r_f_data  <= '0;
    end else begin
      r_rd_pend <= (r_state == S_FETCH);
      r_rd_last <= (r_state == S_FETCH) && w_cnt_end;
      r_f_valid <= r_rd_pend;
      r_f_last  <= r_rd_last;
      r_f_data  <= r_rd_pend ? mem_rdata : '0;
    end
  end

  assign f_gnt   = r_f_gnt;
  assign f_valid = r_f_valid;
  assign f_last  = r_f_last;
  assign f_data  = r_f_data;
  assign ld_ack  = r_ld_ack;
  // Loader read data arrives in the ack cycle and is passed through only while ld_ack is high
  assign ld_rdata = r_rd_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter with a behavioural single-port sync-read memory.
module tb_inst_mem_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_req, ld_we, ld_ack;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata, ld_rdata;
  logic        f_req, f_gnt, f_valid, f_last;
  logic [9:0]  f_addr;
  logic [31:0] f_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  inst_mem_arbiter dut (
    .BRAM_clk (clk),     .BRAM_rst (rst_n),
    .ld_req   (ld_req),  .ld_we    (ld_we),    .ld_addr  (ld_addr),  .ld_wdata (ld_wdata),
    .ld_ack   (ld_ack),  .ld_rdata (ld_rdata),
    .f_req    (f_req),   .f_addr   (f_addr),   .f_gnt    (f_gnt),
    .f_valid  (f_valid), .f_data   (f_data),   .f_last   (f_last),
    .mem_en   (mem_en),  .mem_we   (mem_we),   .mem_addr (mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory preload: word a holds C0DE0000 | a
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return f_gnt | f_valid | f_last | ld_ack | mem_en | mem_we |
           (|mem_addr) | (|mem_wdata) | (|f_data) | (|ld_rdata);
  endfunction

  typedef struct {
    logic        f_req;  logic [9:0] f_addr;
    logic        ld_req; logic ld_we; logic [9:0] ld_addr; logic [31:0] ld_wdata;
    logic        e_gnt;  logic e_en;  logic e_we; logic [9:0] e_addr; logic [31:0] e_wdata;
    logic        e_fv;   logic e_fl;  logic [31:0] e_fd;
    logic        e_ack;  logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t v(input logic fr, input logic [9:0] fa, input logic lr, input logic lw,
                             input logic [9:0] la, input logic [31:0] lwd,
                             input logic eg, input logic een, input logic ewe, input logic [9:0] ea,
                             input logic [31:0] ewd, input logic efv, input logic efl,
                             input logic [31:0] efd, input logic eack, input logic [31:0] erd);
    vec_t r;
    r.f_req = fr; r.f_addr = fa; r.ld_req = lr; r.ld_we = lw; r.ld_addr = la; r.ld_wdata = lwd;
    r.e_gnt = eg; r.e_en = een; r.e_we = ewe; r.e_addr = ea; r.e_wdata = ewd;
    r.e_fv = efv; r.e_fl = efl; r.e_fd = efd; r.e_ack = eack; r.e_rd = erd;
    return r;
  endfunction

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic do_fetch(input logic [9:0] a, input string tag);
    int gc, fc, n;
    logic [9:0] wa;
    gc = -1; fc = -1; n = 0;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = a;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (f_gnt) begin
        if (gc < 0) gc = c;
        f_req = 1'b0;
      end
      if (f_valid) begin
        if (fc < 0) fc = c;
        wa = a + 10'(n);
        chk($sformatf("%s.data%0d", tag, n), f_data, 32'hC0DE0000 | {22'h0, wa});
        chk($sformatf("%s.last%0d", tag, n), 32'(f_last), 32'(n == 3));
        n++;
      end
      @(posedge clk); #1;
    end
    f_req = 1'b0;
    chk({tag, ".gnt_cycle"}, gc, 1);
    chk({tag, ".gnt_to_valid"}, fc - gc, 2);
    chk({tag, ".words"}, n, 4);
  endtask

  task automatic ld_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
    int got;
    got = 0;
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = a;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (ld_ack) begin
        got = 1;
        chk({tag, ".rdata"}, ld_rdata, exp);
        ld_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    ld_req = 1'b0;
    chk({tag, ".acked"}, got, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    int    order [4];
    int    exp4  [4];
    int    ng, nv, n, we_c, we_n, last_c, acks;
    logic [9:0] we_a;

    f_req = 1'b0; f_addr = '0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

    // Burst at 0x010
    vecs[0]  = v('1,10'h010,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[1]  = v('0,10'h000,'0,'0,10'h0,32'h0, '1,'1,'0,10'h010,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[2]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h011,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[3]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h012,32'h0, '1,'0,32'hC0DE0010, '0,32'h0);
    vecs[4]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h013,32'h0, '1,'0,32'hC0DE0011, '0,32'h0);
    vecs[5]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '1,'0,32'hC0DE0012, '0,32'h0);
    vecs[6]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '1,'1,32'hC0DE0013, '0,32'h0);
    vecs[7]  = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '0,'0,32'h0,        '0,32'h0);
    // Burst wrapping past the top of memory
    vecs[8]  = v('1,10'h3FE,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[9]  = v('0,10'h000,'0,'0,10'h0,32'h0, '1,'1,'0,10'h3FE,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[10] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h3FF,32'h0, '0,'0,32'h0,        '0,32'h0);
    vecs[11] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h000,32'h0, '1,'0,32'hC0DE03FE, '0,32'h0);
    vecs[12] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'1,'0,10'h001,32'h0, '1,'0,32'hC0DE03FF, '0,32'h0);
    vecs[13] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '1,'0,32'hC0DE0000, '0,32'h0);
    vecs[14] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '1,'1,32'hC0DE0001, '0,32'h0);
    vecs[15] = v('0,10'h000,'0,'0,10'h0,32'h0, '0,'0,'0,10'h000,32'h0, '0,'0,32'h0,        '0,32'h0);
    // Loader write then read of 0x020
    vecs[16] = v('0,10'h000,'1,'1,10'h020,32'hDEADBEEF, '0,'0,'0,10'h000,32'h0,        '0,'0,32'h0, '0,32'h0);
    vecs[17] = v('0,10'h000,'1,'1,10'h020,32'hDEADBEEF, '0,'1,'1,10'h020,32'hDEADBEEF, '0,'0,32'h0, '0,32'h0);
    vecs[18] = v('0,10'h000,'0,'0,10'h000,32'h0,        '0,'0,'0,10'h000,32'h0,        '0,'0,32'h0, '1,32'h0);
    vecs[19] = v('0,10'h000,'1,'0,10'h020,32'h0,        '0,'0,'0,10'h000,32'h0,        '0,'0,32'h0, '0,32'h0);
    vecs[20] = v('0,10'h000,'1,'0,10'h020,32'h0,        '0,'1,'0,10'h020,32'h0,        '0,'0,32'h0, '0,32'h0);
    vecs[21] = v('0,10'h000,'0,'0,10'h000,32'h0,        '0,'0,'0,10'h000,32'h0,        '0,'0,32'h0, '1,32'hDEADBEEF);
    vecs[22] = v('0,10'h000,'0,'0,10'h000,32'h0,        '0,'0,'0,10'h000,32'h0,        '0,'0,32'h0, '0,32'h0);

    // Reset: every output low
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset.outputs", 32'(any_out()), 32'h0);
    @(negedge clk);
    chk("reset.mem_en", 32'(mem_en), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table: one vector per cycle, inputs after the edge, outputs checked mid-cycle
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      f_req = vecs[i].f_req;   f_addr = vecs[i].f_addr;
      ld_req = vecs[i].ld_req; ld_we = vecs[i].ld_we;
      ld_addr = vecs[i].ld_addr; ld_wdata = vecs[i].ld_wdata;
      @(negedge clk);
      chk($sformatf("v%0d.f_gnt", i),     32'(f_gnt),     32'(vecs[i].e_gnt));
      chk($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(vecs[i].e_en));
      chk($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
      chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d.f_valid", i),   32'(f_valid),   32'(vecs[i].e_fv));
      chk($sformatf("v%0d.f_last", i),    32'(f_last),    32'(vecs[i].e_fl));
      chk($sformatf("v%0d.f_data", i),    f_data,         vecs[i].e_fd);
      chk($sformatf("v%0d.ld_ack", i),    32'(ld_ack),    32'(vecs[i].e_ack));
      chk($sformatf("v%0d.ld_rdata", i),  ld_rdata,       vecs[i].e_rd);
    end

    // Loader write into an in-flight burst waits until after DRAIN
    @(posedge clk); #1; f_req = 1'b1; f_addr = 10'h010;
    @(posedge clk); #1; f_req = 1'b0;
    @(negedge clk);
    chk("hazard.gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); #1;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h011; ld_wdata = 32'h12345678;
    we_c = -1; we_n = 0; last_c = -1; n = 0; acks = 0; we_a = '0;
    for (int c = 2; c < 16; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_n++;
        if (we_c < 0) begin we_c = c; we_a = mem_addr; end
      end
      if (f_valid) begin
        if (n == 1) chk("hazard.old_word", f_data, 32'hC0DE0011);
        if (f_last) last_c = c;
        n++;
      end
      if (ld_ack) begin acks++; ld_req = 1'b0; end
      @(posedge clk); #1;
    end
    ld_req = 1'b0; ld_we = 1'b0;
    chk("hazard.last_cycle", last_c, 6);
    chk("hazard.we_cycle", we_c, 7);
    chk("hazard.we_addr", 32'(we_a), 32'h011);
    chk("hazard.we_count", we_n, 1);
    chk("hazard.acks", acks, 1);
    chk("hazard.words", n, 4);
    ld_read(10'h011, 32'h12345678, "hazard.readback");

    // Simultaneous requests: record the order of the first four grants
`ifdef INST_ARB_RR_EN
    exp4 = '{0, 1, 0, 1};
`else
    exp4 = '{1, 0, 1, 0};
`endif
    order = '{2, 2, 2, 2};
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    f_req = 1'b1; f_addr = 10'h100; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h030;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (f_gnt && ng < 4)  begin order[ng] = 0; ng++; f_req = 1'b0; end
      if (ld_ack && ng < 4) begin order[ng] = 1; ng++; ld_req = 1'b0; end
      @(posedge clk); #1;
      f_req = 1'b1; ld_req = 1'b1;
    end
    f_req = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("arb.grant%0d", k), order[k], exp4[k]);
    repeat (12) @(posedge clk);

    // Reset on the second issue cycle of a burst
    @(posedge clk); #1; f_req = 1'b1; f_addr = 10'h200;
    @(posedge clk); #1; f_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst.issuing", 32'(mem_en), 32'h1);
    chk("midrst.addr", 32'(mem_addr), 32'h201);
    rst_n = 1'b0;
    #1;
    chk("midrst.outputs", 32'(any_out()), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (f_valid) nv++;
    end
    chk("midrst.no_valid", nv, 0);
    do_fetch(10'h040, "midrst.refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
